// File: rtl/drac_pkg.sv
// ---------------------------------------------------------------------------
// drac_pkg
//   Shared types and constants for the fetch stage.
//   - next_pc_sel_t      : select code driven to the fetch PC register
//   - fetch_ctrl_state_t : sequencer states of fetch_ctrl
//   - FETCH_INST_W       : default instruction width
//   - FETCH_RESP_TIMEOUT : default response timeout (used only when
//                          FETCH_TIMEOUT_EN is defined)
// ---------------------------------------------------------------------------
package drac_pkg;

    // PC register source: hold current PC, advance by 4, or load the
    // commit (redirect) target.
    typedef enum logic [1:0] {
        NEXT_PC_SEL_PC     = 2'b00,
        NEXT_PC_SEL_PC_4   = 2'b01,
        NEXT_PC_SEL_COMMIT = 2'b10
    } next_pc_sel_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } fetch_ctrl_state_t;

    localparam int FETCH_INST_W       = 32;
    localparam int FETCH_RESP_TIMEOUT = 255;

endpackage : drac_pkg

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Fetch-stage sequencer. Keeps exactly one icache request outstanding,
//   forwards the returned instruction to decode (directly, or from a hold
//   register while decode is stalled), and cancels in-flight fetches when
//   commit redirects the PC.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     defined   : a WAIT-cycle counter aborts (kill + timeout_o) and reissues
//                 the same PC after RESP_TIMEOUT cycles without a response.
//     undefined : WAIT waits indefinitely; timeout_o is tied low and the
//                 RESP_TIMEOUT parameter does not exist.
//
// Ports
//   clk_i               in   clock
//   rstn_i              in   async reset, active low
//   stall_i             in   decode cannot accept an instruction this cycle
//   redirect_i          in   commit redirect; PC loads pc_commit next edge
//   pc_req_valid_i      in   current PC is fetchable
//   icache_ready_i      in   icache accepts a request this cycle
//   icache_resp_valid_i in   icache returns data for the outstanding request
//   icache_inst_i       in   returned instruction
//   next_pc_sel_o       out  PC source select
//   icache_req_o        out  request valid to icache
//   icache_kill_o       out  abort outstanding request (1-cycle pulse)
//   fetch_valid_o       out  instruction valid to decode
//   fetch_inst_o        out  instruction to decode (0 when not valid)
//   timeout_o           out  1-cycle pulse on response timeout
// ---------------------------------------------------------------------------
module fetch_ctrl
    import drac_pkg::*;
#(
    parameter int INST_W = FETCH_INST_W
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int RESP_TIMEOUT = FETCH_RESP_TIMEOUT
`endif
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic              pc_req_valid_i,
    input  logic              icache_ready_i,
    input  logic              icache_resp_valid_i,
    input  logic [INST_W-1:0] icache_inst_i,
    output next_pc_sel_t      next_pc_sel_o,
    output logic              icache_req_o,
    output logic              icache_kill_o,
    output logic              fetch_valid_o,
    output logic [INST_W-1:0] fetch_inst_o,
    output logic              timeout_o
);

    fetch_ctrl_state_t state_q, state_d;
    logic [INST_W-1:0] hold_q;
    logic              capture;
    logic              timeout_hit;

    // Response capture while decode is stalled; the hold register then
    // presents the instruction from HOLD.
    assign capture = (state_q == WAIT) && icache_resp_valid_i && !redirect_i && stall_i;

    // -----------------------------------------------------------------------
    // Optional response timeout counter
    // -----------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // wait_cnt_q holds the number of WAIT cycles already completed, so the
    // timeout fires in the RESP_TIMEOUT-th WAIT cycle without a response.
    assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CNT_W'(RESP_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wait_cnt_q <= '0;
        end else if ((state_q == WAIT) && (state_d == WAIT)) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the hold register is a single data word, not a memory; it is reset
    // so the instruction bus starts from a known value after reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hold_q <= '0;
        end else if (capture) begin
            hold_q <= icache_inst_i;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = REQ;

            REQ: begin
                if (pc_req_valid_i && !redirect_i && icache_ready_i) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_i) begin
                    // A response arriving with the redirect is simply dropped;
                    // without one the killed request still has to drain.
                    state_d = icache_resp_valid_i ? REQ : DRAIN;
                end else if (icache_resp_valid_i) begin
                    state_d = stall_i ? HOLD : REQ;
                end else if (timeout_hit) begin
                    state_d = REQ;
                end
            end

            HOLD: begin
                if (redirect_i || !stall_i) begin
                    state_d = REQ;
                end
            end

            DRAIN: begin
                // The response of the killed request is discarded; a further
                // redirect here needs no second kill.
                if (icache_resp_valid_i) begin
                    state_d = REQ;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    always_comb begin
        next_pc_sel_o = redirect_i ? NEXT_PC_SEL_COMMIT : NEXT_PC_SEL_PC;
        icache_req_o  = 1'b0;
        icache_kill_o = 1'b0;
        fetch_valid_o = 1'b0;
        fetch_inst_o  = '0;
        timeout_o     = 1'b0;

        unique case (state_q)
            REQ: begin
                icache_req_o = pc_req_valid_i && !redirect_i;
            end

            WAIT: begin
                if (redirect_i) begin
                    icache_kill_o = !icache_resp_valid_i;
                end else if (icache_resp_valid_i) begin
                    if (!stall_i) begin
                        fetch_valid_o = 1'b1;
                        fetch_inst_o  = icache_inst_i;
                        next_pc_sel_o = NEXT_PC_SEL_PC_4;
                    end
                end else if (timeout_hit) begin
                    // Reissue the same PC: the select stays on PC.
                    icache_kill_o = 1'b1;
                    timeout_o     = 1'b1;
                end
            end

            HOLD: begin
                if (!redirect_i) begin
                    fetch_valid_o = 1'b1;
                    fetch_inst_o  = hold_q;
                    if (!stall_i) begin
                        next_pc_sel_o = NEXT_PC_SEL_PC_4;
                    end
                end
            end

            default: ;
        endcase
    end

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl: directed vector table, hand-written
//   multi-cycle sequences, then randomized traffic against a behavioural
//   model of the fetch protocol (outstanding / holding / draining flags).
//   With FETCH_TIMEOUT_EN defined the DUT is built with RESP_TIMEOUT=4.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
    import drac_pkg::*;

    localparam int TB_RT = 4;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         stall_i = 1'b0;
    logic         redirect_i = 1'b0;
    logic         pc_req_valid_i = 1'b0;
    logic         icache_ready_i = 1'b0;
    logic         icache_resp_valid_i = 1'b0;
    logic [31:0]  icache_inst_i = '0;
    next_pc_sel_t next_pc_sel_o;
    logic         icache_req_o;
    logic         icache_kill_o;
    logic         fetch_valid_o;
    logic [31:0]  fetch_inst_o;
    logic         timeout_o;

    fetch_ctrl #(
        .INST_W(32)
`ifdef FETCH_TIMEOUT_EN
        ,
        .RESP_TIMEOUT(TB_RT)
`endif
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .stall_i            (stall_i),
        .redirect_i         (redirect_i),
        .pc_req_valid_i     (pc_req_valid_i),
        .icache_ready_i     (icache_ready_i),
        .icache_resp_valid_i(icache_resp_valid_i),
        .icache_inst_i      (icache_inst_i),
        .next_pc_sel_o      (next_pc_sel_o),
        .icache_req_o       (icache_req_o),
        .icache_kill_o      (icache_kill_o),
        .fetch_valid_o      (fetch_valid_o),
        .fetch_inst_o       (fetch_inst_o),
        .timeout_o          (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         rd;
        logic         st;
        logic         pv;
        logic         rdy;
        logic         rsp;
        logic [31:0]  inst;
        next_pc_sel_t e_sel;
        logic         e_req;
        logic         e_kill;
        logic         e_val;
        logic         e_to;
        logic [31:0]  e_inst;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic st, input logic pv, input logic rdy,
                                input logic rsp, input logic [31:0] inst, input next_pc_sel_t s,
                                input logic req, input logic kill, input logic val, input logic to,
                                input logic [31:0] ei);
        vec_t v;
        v.rd = rd; v.st = st; v.pv = pv; v.rdy = rdy; v.rsp = rsp; v.inst = inst;
        v.e_sel = s; v.e_req = req; v.e_kill = kill; v.e_val = val; v.e_to = to; v.e_inst = ei;
        return v;
    endfunction

    // Drive one cycle of inputs just after the rising edge, compare the
    // combinational outputs mid-cycle, then advance to the next edge.
    task automatic step(input string name, input vec_t v);
        redirect_i          = v.rd;
        stall_i             = v.st;
        pc_req_valid_i      = v.pv;
        icache_ready_i      = v.rdy;
        icache_resp_valid_i = v.rsp;
        icache_inst_i       = v.inst;
        #2;
        check({name, ".sel"},   32'(next_pc_sel_o), 32'(v.e_sel));
        check({name, ".req"},   32'(icache_req_o),  32'(v.e_req));
        check({name, ".kill"},  32'(icache_kill_o), 32'(v.e_kill));
        check({name, ".valid"}, 32'(fetch_valid_o), 32'(v.e_val));
        check({name, ".tmo"},   32'(timeout_o),     32'(v.e_to));
        if (v.e_val) check({name, ".inst"}, fetch_inst_o, v.e_inst);
        @(posedge clk_i);
        #1;
    endtask

    // Behavioural model of the fetch protocol.
    bit started, outstanding, draining, holding;
    logic [31:0] held;
    int wait_cycles;

    task automatic model_reset();
        started = 0; outstanding = 0; draining = 0; holding = 0; held = '0; wait_cycles = 0;
    endtask

    task automatic model_cycle(inout vec_t v);
        v.e_sel  = v.rd ? NEXT_PC_SEL_COMMIT : NEXT_PC_SEL_PC;
        v.e_req  = 0; v.e_kill = 0; v.e_val = 0; v.e_to = 0; v.e_inst = '0;
        if (!started) begin
            started = 1;
        end else if (holding) begin
            if (v.rd) holding = 0;
            else begin
                v.e_val = 1; v.e_inst = held;
                if (!v.st) begin v.e_sel = NEXT_PC_SEL_PC_4; holding = 0; end
            end
        end else if (draining) begin
            if (v.rsp) draining = 0;
        end else if (outstanding) begin
            if (v.rd) begin
                outstanding = 0;
                if (!v.rsp) begin v.e_kill = 1; draining = 1; end
            end else if (v.rsp) begin
                outstanding = 0;
                if (v.st) begin holding = 1; held = v.inst; end
                else begin v.e_val = 1; v.e_inst = v.inst; v.e_sel = NEXT_PC_SEL_PC_4; end
            end else begin
`ifdef FETCH_TIMEOUT_EN
                if (wait_cycles + 1 == TB_RT) begin
                    v.e_kill = 1; v.e_to = 1; outstanding = 0;
                end else wait_cycles++;
`else
                wait_cycles++;
`endif
            end
        end else begin
            v.e_req = v.pv && !v.rd;
            if (v.e_req && v.rdy) begin outstanding = 1; wait_cycles = 0; end
        end
    endtask

    localparam next_pc_sel_t PC = NEXT_PC_SEL_PC;
    localparam next_pc_sel_t P4 = NEXT_PC_SEL_PC_4;
    localparam next_pc_sel_t CM = NEXT_PC_SEL_COMMIT;

    vec_t tbl[21];

    initial begin
        //             rd st pv rdy rsp inst           sel req kill val to e_inst
        tbl[0]  = mk(0, 0, 1, 1, 0, 32'h0,          PC, 0, 0, 0, 0, 32'h0);          // IDLE
        tbl[1]  = mk(0, 0, 1, 1, 0, 32'h0,          PC, 1, 0, 0, 0, 32'h0);          // REQ fire
        tbl[2]  = mk(0, 0, 1, 1, 1, 32'hA1A1_0001,  P4, 0, 0, 1, 0, 32'hA1A1_0001);  // resp
        tbl[3]  = mk(0, 0, 1, 1, 0, 32'h0,          PC, 1, 0, 0, 0, 32'h0);
        tbl[4]  = mk(0, 0, 1, 1, 1, 32'hA2A2_0002,  P4, 0, 0, 1, 0, 32'hA2A2_0002);
        tbl[5]  = mk(0, 0, 1, 1, 0, 32'h0,          PC, 1, 0, 0, 0, 32'h0);
        tbl[6]  = mk(1, 0, 1, 1, 0, 32'h0,          CM, 0, 1, 0, 0, 32'h0);          // redirect in WAIT
        tbl[7]  = mk(0, 0, 1, 1, 0, 32'h0,          PC, 0, 0, 0, 0, 32'h0);          // DRAIN
        tbl[8]  = mk(0, 0, 1, 1, 1, 32'hBAD0_BAD0,  PC, 0, 0, 0, 0, 32'h0);          // late resp dropped
        tbl[9]  = mk(0, 0, 1, 1, 0, 32'h0,          PC, 1, 0, 0, 0, 32'h0);
        tbl[10] = mk(1, 0, 1, 1, 1, 32'hBAD1_BAD1,  CM, 0, 0, 0, 0, 32'h0);          // redirect + resp
        tbl[11] = mk(0, 0, 1, 0, 0, 32'h0,          PC, 1, 0, 0, 0, 32'h0);          // back in REQ
        tbl[12] = mk(0, 0, 0, 1, 0, 32'h0,          PC, 0, 0, 0, 0, 32'h0);          // pc invalid x5
        tbl[13] = mk(0, 0, 0, 1, 0, 32'h0,          PC, 0, 0, 0, 0, 32'h0);
        tbl[14] = mk(0, 0, 0, 1, 0, 32'h0,          PC, 0, 0, 0, 0, 32'h0);
        tbl[15] = mk(0, 0, 0, 1, 0, 32'h0,          PC, 0, 0, 0, 0, 32'h0);
        tbl[16] = mk(0, 0, 0, 1, 0, 32'h0,          PC, 0, 0, 0, 0, 32'h0);
        tbl[17] = mk(1, 0, 1, 1, 0, 32'h0,          CM, 0, 0, 0, 0, 32'h0);          // redirect in REQ
        tbl[18] = mk(0, 0, 1, 1, 0, 32'h0,          PC, 1, 0, 0, 0, 32'h0);
        tbl[19] = mk(0, 0, 1, 1, 0, 32'h0,          PC, 0, 0, 0, 0, 32'h0);          // WAIT idle
        tbl[20] = mk(0, 0, 1, 1, 1, 32'hA3A3_0003,  P4, 0, 0, 1, 0, 32'hA3A3_0003);

        // Reset state
        #12;
        check("rst.sel",   32'(next_pc_sel_o), 32'(NEXT_PC_SEL_PC));
        check("rst.req",   32'(icache_req_o),  32'd0);
        check("rst.kill",  32'(icache_kill_o), 32'd0);
        check("rst.valid", 32'(fetch_valid_o), 32'd0);
        check("rst.inst",  fetch_inst_o,       32'd0);
        check("rst.tmo",   32'(timeout_o),     32'd0);
        @(posedge clk_i);
        #1 rstn_i = 1'b1;

        for (int i = 0; i < 21; i++) step($sformatf("tbl%0d", i), tbl[i]);

        // Stall on response: HOLD presents 0x13 until decode frees up.
        step("hold.fire",  mk(0, 0, 1, 1, 0, 32'h0,        PC, 1, 0, 0, 0, 32'h0));
        step("hold.resp",  mk(0, 1, 1, 1, 1, 32'h0000_0013, PC, 0, 0, 0, 0, 32'h0));
        step("hold.st1",   mk(0, 1, 1, 1, 0, 32'h0,        PC, 0, 0, 1, 0, 32'h0000_0013));
        step("hold.st2",   mk(0, 1, 1, 1, 0, 32'h0,        PC, 0, 0, 1, 0, 32'h0000_0013));
        step("hold.rel",   mk(0, 0, 1, 1, 0, 32'h0,        P4, 0, 0, 1, 0, 32'h0000_0013));
        step("hold.req",   mk(0, 0, 1, 0, 0, 32'h0,        PC, 1, 0, 0, 0, 32'h0));

        // Redirect while holding drops the instruction.
        step("hrd.fire",   mk(0, 0, 1, 1, 0, 32'h0,        PC, 1, 0, 0, 0, 32'h0));
        step("hrd.resp",   mk(0, 1, 1, 1, 1, 32'h0000_00AB, PC, 0, 0, 0, 0, 32'h0));
        step("hrd.redir",  mk(1, 1, 1, 1, 0, 32'h0,        CM, 0, 0, 0, 0, 32'h0));
        step("hrd.req",    mk(0, 0, 1, 1, 0, 32'h0,        PC, 1, 0, 0, 0, 32'h0));

        // Second redirect during DRAIN: no second kill.
        step("drn.kill",   mk(1, 0, 1, 1, 0, 32'h0,        CM, 0, 1, 0, 0, 32'h0));
        step("drn.redir",  mk(1, 0, 1, 1, 0, 32'h0,        CM, 0, 0, 0, 0, 32'h0));
        step("drn.resp",   mk(0, 0, 1, 1, 1, 32'hDEAD_BEEF, PC, 0, 0, 0, 0, 32'h0));
        step("drn.req",    mk(0, 0, 1, 1, 0, 32'h0,        PC, 1, 0, 0, 0, 32'h0));

        // Response timeout (now in WAIT).
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < TB_RT - 1; i++)
            step($sformatf("tmo.w%0d", i), mk(0, 0, 1, 1, 0, 32'h0, PC, 0, 0, 0, 0, 32'h0));
        step("tmo.fire",   mk(0, 0, 1, 1, 0, 32'h0,        PC, 0, 1, 0, 1, 32'h0));
        step("tmo.reiss",  mk(0, 0, 1, 0, 0, 32'h0,        PC, 1, 0, 0, 0, 32'h0));
`else
        for (int i = 0; i < TB_RT + 2; i++)
            step($sformatf("tmo.w%0d", i), mk(0, 0, 1, 1, 0, 32'h0, PC, 0, 0, 0, 0, 32'h0));
        step("tmo.resp",   mk(0, 0, 1, 1, 1, 32'h0C0C_0C0C, P4, 0, 0, 1, 0, 32'h0C0C_0C0C));
`endif

        // Async reset in the middle of a transaction: everything drops, no kill.
        step("mrst.fire",  mk(0, 0, 1, 1, 0, 32'h0,        PC, 1, 0, 0, 0, 32'h0));
        icache_resp_valid_i = 1'b1;
        icache_inst_i       = 32'h1234_5678;
        rstn_i              = 1'b0;
        #1;
        check("mrst.valid", 32'(fetch_valid_o), 32'd0);
        check("mrst.kill",  32'(icache_kill_o), 32'd0);
        check("mrst.req",   32'(icache_req_o),  32'd0);
        check("mrst.sel",   32'(next_pc_sel_o), 32'(NEXT_PC_SEL_PC));
        @(posedge clk_i);
        #1 rstn_i = 1'b1;

        // Randomized traffic against the behavioural model.
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            vec_t v;
            v.rd   = ($urandom_range(0, 11) == 0);
            v.st   = ($urandom_range(0, 2) == 0);
            v.pv   = ($urandom_range(0, 7) != 0);
            v.rdy  = $urandom_range(0, 1) == 1;
            v.rsp  = $urandom_range(0, 1) == 1;
            v.inst = $urandom;
            model_cycle(v);
            step($sformatf("rnd%0d", i), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_ctrl
